instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the 64-bit program counter and drives it to the instruction memory.
- Captures the combinationally returned 32-bit instruction into a 2-entry fetch queue, tagged with its PC.
- Hands {pc, instruction} to decode over a valid/ready handshake; supports branch redirect and halts at the end of memory.

---
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from instruction memory into a
// 2-entry queue tagged with PC, and hands entries to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] programCounter,
  input  logic [31:0] CPU_Instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state, stateNext;
  logic [63:0] pc;
  logic [63:0] qPc    [QDEPTH];
  logic [31:0] qInstr [QDEPTH];
  logic        head, tail;
  logic [1:0]  count;
  logic        inRange, push, pop;

  assign programCounter = pc;
  assign id_valid       = (count != 2'd0);
  assign id_pc          = qPc[head];
  assign id_instr       = qInstr[head];
  assign halted         = (state == HALTED);

  assign inRange = (pc + 64'd3) < 64'(MEM_BYTES);
  assign pop     = id_valid & id_ready;
  assign push    = (state == FETCH) & inRange & ((count < 2'(QDEPTH)) | pop);

  // A redirect overrides the end-of-memory rule; a misaligned target parks in HALTED.
  always_comb begin
    stateNext = state;
    if (redirect_valid) begin
      stateNext = (redirect_pc[1:0] == 2'b00) ? FETCH : HALTED;
    end else if (state == FETCH && !inRange) begin
      stateNext = HALTED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        qPc[i]    <= '0;
        qInstr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc           <= redirect_pc;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) begin
        qPc[tail]    <= pc;
        qInstr[tail] <= CPU_Instruction;
        tail         <= ~tail;
        pc           <= pc + 64'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a 64-byte
// big-endian instruction memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] programCounter;
  logic [31:0] CPU_Instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        halted;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [5:0] pcIdx;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (64'd0),
    .MEM_BYTES(64),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .programCounter (programCounter),
    .CPU_Instruction(CPU_Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  assign pcIdx = programCounter[5:0];
  assign CPU_Instruction = (programCounter < 64'd61) ?
      {mem[pcIdx], mem[pcIdx + 6'd1], mem[pcIdx + 6'd2], mem[pcIdx + 6'd3]} : 32'h0;

  function automatic logic [31:0] memWord(input int unsigned a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", id_valid); end
    checks++; if (id_pc !== 64'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", id_pc); end
    checks++; if (id_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", id_instr); end
    checks++; if (programCounter !== 64'd0) begin errors++; $display("FAIL rst_progc got %h exp 0", programCounter); end
    checks++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", halted, misalign_err); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'd0) begin errors++; $display("FAIL c1_head got v%0b pc %h exp v1 pc 0", id_valid, id_pc); end
    checks++; if (id_instr !== 32'hF842802A) begin errors++; $display("FAIL c1_instr got %h exp F842802A", id_instr); end
    checks++; if (programCounter !== 64'd4) begin errors++; $display("FAIL c1_progc got %h exp 4", programCounter); end
    @(negedge clk);
    checks++; if (id_pc !== 64'd4 || id_instr !== 32'hCB03004B) begin errors++; $display("FAIL c2_head got %h/%h exp 4/CB03004B", id_pc, id_instr); end
    checks++; if (programCounter !== 64'd8) begin errors++; $display("FAIL c2_progc got %h exp 8", programCounter); end
    @(negedge clk);
    checks++; if (id_pc !== 64'd8 || id_instr !== memWord(8)) begin errors++; $display("FAIL c3_head got %h/%h exp 8/%h", id_pc, id_instr, memWord(8)); end
    checks++; if (programCounter !== 64'd12) begin errors++; $display("FAIL c3_progc got %h exp c", programCounter); end
  endtask

  task automatic test_stall();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'd0) begin errors++; $display("FAIL stall_head[%0d] got v%0b pc %h exp v1 pc 0", i, id_valid, id_pc); end
    end
    checks++; if (programCounter !== 64'd8) begin errors++; $display("FAIL stall_progc got %h exp 8", programCounter); end
    id_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'(4 * i)) begin errors++; $display("FAIL drain_head[%0d] got v%0b pc %h exp %h", i, id_valid, id_pc, 4 * i); end
    end
  endtask

  task automatic test_redirect_full();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; id_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (programCounter !== 64'd8) begin errors++; $display("FAIL full_progc got %h exp 8", programCounter); end
    redirect_valid = 1'b1; redirect_pc = 64'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", id_valid); end
    checks++; if (programCounter !== 64'h20) begin errors++; $display("FAIL redir_progc got %h exp 20", programCounter); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h20 || id_instr !== memWord(32)) begin errors++; $display("FAIL redir_head got v%0b %h/%h exp v1 20/%h", id_valid, id_pc, id_instr, memWord(32)); end
  endtask

  task automatic test_end_of_memory();
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h30;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (programCounter !== 64'h30 || id_valid !== 1'b0) begin errors++; $display("FAIL eom_start got pc %h v%0b exp 30 v0", programCounter, id_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'(48 + 4 * i)) begin errors++; $display("FAIL eom_head[%0d] got v%0b pc %h exp %h", i, id_valid, id_pc, 48 + 4 * i); end
    end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL eom_halt got v%0b h%0b exp v0 h1", id_valid, halted); end
    checks++; if (programCounter !== 64'd64) begin errors++; $display("FAIL eom_progc got %h exp 40", programCounter); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || programCounter !== 64'd64) begin errors++; $display("FAIL eom_hold got h%0b pc %h exp h1 40", halted, programCounter); end
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || programCounter !== 64'h40) begin errors++; $display("FAIL oor_enter got h%0b pc %h exp h0 40", halted, programCounter); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL oor_halt got h%0b v%0b exp h1 v0", halted, id_valid); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 64'h22;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b1 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_flags got h%0b m%0b exp h1 m1", halted, misalign_err); end
    checks++; if (programCounter !== 64'h22 || id_valid !== 1'b0) begin errors++; $display("FAIL mis_pc got %h v%0b exp 22 v0", programCounter, id_valid); end
    repeat (2) @(negedge clk);
    checks++; if (id_valid !== 1'b0 || programCounter !== 64'h22 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_nopush got v%0b pc %h m%0b exp v0 22 m1", id_valid, programCounter, misalign_err); end
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0 || misalign_err !== 1'b0 || programCounter !== 64'd0) begin errors++; $display("FAIL mis_clear got h%0b m%0b pc %h exp h0 m0 0", halted, misalign_err, programCounter); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'd0 || id_instr !== 32'hF842802A) begin errors++; $display("FAIL mis_resume got v%0b %h/%h exp v1 0/F842802A", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_reset_midstream();
    id_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (programCounter !== 64'd8 || id_pc !== 64'd0) begin errors++; $display("FAIL mid_pre got pc %h head %h exp 8 0", programCounter, id_pc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || id_pc !== 64'd0 || id_instr !== 32'd0) begin errors++; $display("FAIL mid_clear got v%0b %h/%h exp v0 0/0", id_valid, id_pc, id_instr); end
    checks++; if (programCounter !== 64'd0 || halted !== 1'b0) begin errors++; $display("FAIL mid_progc got %h h%0b exp 0 h0", programCounter, halted); end
    @(negedge clk);
    reset = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'd0) begin errors++; $display("FAIL mid_first got v%0b pc %h exp v1 0", id_valid, id_pc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    mem[0] = 8'hF8; mem[1] = 8'h42; mem[2] = 8'h80; mem[3] = 8'h2A;
    mem[4] = 8'hCB; mem[5] = 8'h03; mem[6] = 8'h00; mem[7] = 8'h4B;
    for (int i = 8; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    test_reset();
    test_stall();
    test_redirect_full();
    test_end_of_memory();
    test_misalign();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
